// File: rtl/fft_seq_pkg.sv
// Shared definitions for the FFT frame path: sequencer state encoding and
// the default frame/buffer geometry used by the buffer and FFT wrappers.
package fft_seq_pkg;

   localparam int DEF_N_LOG2 = 9;
   localparam int DEF_NUM_CH = 2;

   typedef enum logic [2:0] {
      ST_RST     = 3'd0,
      ST_LISTEN  = 3'd1,
      ST_PREPARE = 3'd2,
      ST_LOAD    = 3'd3,
      ST_WAIT    = 3'd4,
      ST_DRAIN   = 3'd5
   } state_t;

endpackage

// File: rtl/fft_frame_sequencer_counter.sv
// Up-counter with synchronous clear and count enable. tc flags that the
// current count equals TC_VAL; the count wraps naturally at 2**WIDTH.
module seq_counter #(
   parameter int               WIDTH  = 4,
   parameter logic [WIDTH-1:0] TC_VAL = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: clear has priority over increment.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign tc    = (count_q == TC_VAL);

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer between the ADC sample buffers and the FFT core / peak
// detector. Fills all buffers, streams one frame into the FFT, waits for the
// transform with a bounded timeout, then drains the output bins under
// backpressure.
//
// Handshake: a bin transfers on every cycle where out_valid && out_ready are
// both high at the rising edge; out_valid stays high and out_index holds
// until that happens, and out_valid never depends on out_ready.
//
// All outputs are flops loaded from next-state decode, so they behave as Moore
// outputs of the registered state with no combinational input-to-output path.
module fft_frame_sequencer
   import fft_seq_pkg::*;
#(
   parameter int N_LOG2      = DEF_N_LOG2,
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int TIMEOUT_CYC = 4096,
   parameter int FCNT_W      = 16,
   localparam int TMR_W      = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [NUM_CH-1:0] buf_full,
   input  logic              fft_done,
   input  logic              out_ready,
   input  logic              err_clear,
   output logic [NUM_CH-1:0] buf_write_en,
   output logic              buf_read,
   output logic [N_LOG2-1:0] rd_index,
   output logic              fft_reset,
   output logic              fft_start,
   output logic              peak_reset,
   output logic              out_valid,
   output logic [N_LOG2-1:0] out_index,
   output logic [FCNT_W-1:0] frame_count,
   output logic              timeout_err,
   output logic              busy,
   output state_t            dbg_state,
   output logic [TMR_W-1:0]  dbg_timer
);

   localparam logic [N_LOG2-1:0] LAST_IDX = {N_LOG2{1'b1}};
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

   state_t            state_q, state_d;
   logic [FCNT_W-1:0] frame_count_q, frame_count_d;
   logic              timeout_err_q, timeout_err_d;
   logic [NUM_CH-1:0] buf_write_en_q, buf_write_en_d;
   logic              buf_read_q, buf_read_d;
   logic              fft_reset_q, fft_reset_d;
   logic              fft_start_q, fft_start_d;
   logic              peak_reset_q, peak_reset_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;
   logic              set_err;

   logic              rd_tc;
   logic              out_tc;
   logic              tmr_tc;

   // Sample index for LOAD: restarts in PREPARE, steps once per read cycle.
   seq_counter #(.WIDTH(N_LOG2), .TC_VAL(LAST_IDX)) u_rd_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (state_q == ST_PREPARE),
      .en    (state_q == ST_LOAD),
      .count (rd_index),
      .tc    (rd_tc)
   );

   // Bin index for DRAIN: zeroed while waiting, steps on each accepted beat.
   seq_counter #(.WIDTH(N_LOG2), .TC_VAL(LAST_IDX)) u_out_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (state_q == ST_WAIT),
      .en    ((state_q == ST_DRAIN) && out_ready),
      .count (out_index),
      .tc    (out_tc)
   );

   // FFT completion timer: runs only in WAIT, held at zero elsewhere.
   seq_counter #(.WIDTH(TMR_W), .TC_VAL(TMR_LAST)) u_wait_tmr (
      .clk   (clk),
      .reset (reset),
      .clear (state_q != ST_WAIT),
      .en    (state_q == ST_WAIT),
      .count (dbg_timer),
      .tc    (tmr_tc)
   );

   // Next-state, sticky error, frame count and output decode of the next state.
   always_comb begin
      state_d       = state_q;
      frame_count_d = frame_count_q;
      set_err       = 1'b0;
      unique case (state_q)
         ST_RST:     state_d = ST_LISTEN;
         ST_LISTEN:  if (enable && (&buf_full)) state_d = ST_PREPARE;
         ST_PREPARE: state_d = ST_LOAD;
         ST_LOAD:    if (rd_tc) state_d = ST_WAIT;
         ST_WAIT: begin
            // A done arriving on the expiry cycle still counts as success.
            if (fft_done) begin
               state_d = ST_DRAIN;
            end else if (tmr_tc) begin
               state_d = ST_LISTEN;
               set_err = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (out_ready && out_tc) begin
               state_d       = ST_LISTEN;
               frame_count_d = frame_count_q + 1'b1;
            end
         end
         default:    state_d = ST_RST;
      endcase

      // Setting beats clearing when both happen in one cycle.
      if (set_err) begin
         timeout_err_d = 1'b1;
      end else if (err_clear) begin
         timeout_err_d = 1'b0;
      end else begin
         timeout_err_d = timeout_err_q;
      end

      buf_write_en_d = (state_d == ST_LISTEN) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};
      fft_reset_d    = (state_d == ST_RST) || (state_d == ST_LISTEN);
      peak_reset_d   = (state_d == ST_LISTEN);
      fft_start_d    = (state_d == ST_PREPARE);
      buf_read_d     = (state_d == ST_LOAD);
      out_valid_d    = (state_d == ST_DRAIN);
      busy_d         = (state_d != ST_RST) && (state_d != ST_LISTEN);
   end

   // State, status and registered output flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_RST;
         frame_count_q  <= '0;
         timeout_err_q  <= 1'b0;
         buf_write_en_q <= '0;
         buf_read_q     <= 1'b0;
         fft_reset_q    <= 1'b1;
         fft_start_q    <= 1'b0;
         peak_reset_q   <= 1'b0;
         out_valid_q    <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         frame_count_q  <= frame_count_d;
         timeout_err_q  <= timeout_err_d;
         buf_write_en_q <= buf_write_en_d;
         buf_read_q     <= buf_read_d;
         fft_reset_q    <= fft_reset_d;
         fft_start_q    <= fft_start_d;
         peak_reset_q   <= peak_reset_d;
         out_valid_q    <= out_valid_d;
         busy_q         <= busy_d;
      end
   end

   assign dbg_state    = state_q;
   assign frame_count  = frame_count_q;
   assign timeout_err  = timeout_err_q;
   assign buf_write_en = buf_write_en_q;
   assign buf_read     = buf_read_q;
   assign fft_reset    = fft_reset_q;
   assign fft_start    = fft_start_q;
   assign peak_reset   = peak_reset_q;
   assign out_valid    = out_valid_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with an 8-sample frame, two buffers,
// a 16-cycle FFT timeout and a 2-bit frame counter.
module tb_fft_frame_sequencer;
   import fft_seq_pkg::*;

   localparam int N_LOG2      = 3;
   localparam int NUM_CH      = 2;
   localparam int TIMEOUT_CYC = 16;
   localparam int FCNT_W      = 2;
   localparam int FRAME_LEN   = 1 << N_LOG2;
   localparam int TMR_W       = $clog2(TIMEOUT_CYC + 1);

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              enable = 1'b0;
   logic [NUM_CH-1:0] buf_full = '0;
   logic              fft_done = 1'b0;
   logic              out_ready = 1'b0;
   logic              err_clear = 1'b0;
   logic [NUM_CH-1:0] buf_write_en;
   logic              buf_read;
   logic [N_LOG2-1:0] rd_index;
   logic              fft_reset;
   logic              fft_start;
   logic              peak_reset;
   logic              out_valid;
   logic [N_LOG2-1:0] out_index;
   logic [FCNT_W-1:0] frame_count;
   logic              timeout_err;
   logic              busy;
   state_t            dbg_state;
   logic [TMR_W-1:0]  dbg_timer;

   int n_cmp = 0;
   int n_err = 0;
   int start_cnt = 0;
   int read_cnt = 0;
   int beat_cnt = 0;

   fft_frame_sequencer #(
      .N_LOG2      (N_LOG2),
      .NUM_CH      (NUM_CH),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .FCNT_W      (FCNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .buf_full     (buf_full),
      .fft_done     (fft_done),
      .out_ready    (out_ready),
      .err_clear    (err_clear),
      .buf_write_en (buf_write_en),
      .buf_read     (buf_read),
      .rd_index     (rd_index),
      .fft_reset    (fft_reset),
      .fft_start    (fft_start),
      .peak_reset   (peak_reset),
      .out_valid    (out_valid),
      .out_index    (out_index),
      .frame_count  (frame_count),
      .timeout_err  (timeout_err),
      .busy         (busy),
      .dbg_state    (dbg_state),
      .dbg_timer    (dbg_timer)
   );

   // Clock generation.
   always #5 clk = ~clk;

   // Event counters sampled mid-cycle: start pulses, read cycles, accepted beats.
   always @(negedge clk) begin
      if (fft_start) start_cnt++;
      if (buf_read) read_cnt++;
      if (out_valid && out_ready) beat_cnt++;
   end

   // Absolute time bound for the whole run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      enable = 1'b0;
      buf_full = '0;
      fft_done = 1'b0;
      out_ready = 1'b0;
      err_clear = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // From LISTEN: fill, run PREPARE and the full LOAD, end on the first WAIT cycle.
   task automatic start_frame();
      enable = 1'b1;
      buf_full = '1;
      tick();
      buf_full = '0;
      repeat (FRAME_LEN + 1) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (dbg_state !== ST_RST) begin
         n_err++;
         $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_RST);
      end
      n_cmp++;
      if ({fft_reset, buf_write_en, buf_read, fft_start, peak_reset, out_valid, busy, timeout_err} !== 9'b1_00_000000) begin
         n_err++;
         $display("FAIL reset_outputs: got %b want %b",
                  {fft_reset, buf_write_en, buf_read, fft_start, peak_reset, out_valid, busy, timeout_err}, 9'b1_00_000000);
      end
      n_cmp++;
      if ({rd_index, out_index, frame_count, dbg_timer} !== 13'd0) begin
         n_err++;
         $display("FAIL reset_counters: got %b want 0", {rd_index, out_index, frame_count, dbg_timer});
      end
      reset = 1'b0;
      tick();
      n_cmp++;
      if ({dbg_state, buf_write_en, fft_reset, peak_reset, busy} !== {ST_LISTEN, 2'b11, 1'b1, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL listen_after_release: state %0d wen %b fft_reset %b peak_reset %b busy %b",
                  dbg_state, buf_write_en, fft_reset, peak_reset, busy);
      end
   endtask

   task automatic test_frame();
      int s0, r0, b0;
      do_reset();
      s0 = start_cnt;
      r0 = read_cnt;
      b0 = beat_cnt;
      enable = 1'b1;
      buf_full = 2'b11;
      out_ready = 1'b1;
      tick();
      n_cmp++;
      if ({dbg_state, fft_start, buf_write_en, busy} !== {ST_PREPARE, 1'b1, 2'b00, 1'b1}) begin
         n_err++;
         $display("FAIL prepare: state %0d start %b wen %b busy %b", dbg_state, fft_start, buf_write_en, busy);
      end
      buf_full = 2'b00;
      for (int i = 0; i < FRAME_LEN; i++) begin
         tick();
         n_cmp++;
         if ({buf_read, rd_index} !== {1'b1, 3'(i)}) begin
            n_err++;
            $display("FAIL load_idx%0d: read %b idx %0d want read 1 idx %0d", i, buf_read, rd_index, i);
         end
      end
      tick();
      n_cmp++;
      if ({dbg_state, buf_read, busy} !== {ST_WAIT, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL enter_wait: state %0d read %b busy %b", dbg_state, buf_read, busy);
      end
      repeat (4) tick();
      fft_done = 1'b1;
      tick();
      fft_done = 1'b0;
      for (int i = 0; i < FRAME_LEN; i++) begin
         n_cmp++;
         if ({out_valid, out_index} !== {1'b1, 3'(i)}) begin
            n_err++;
            $display("FAIL drain_idx%0d: valid %b idx %0d want valid 1 idx %0d", i, out_valid, out_index, i);
         end
         tick();
      end
      out_ready = 1'b0;
      n_cmp++;
      if ({dbg_state, out_valid, frame_count} !== {ST_LISTEN, 1'b0, 2'd1}) begin
         n_err++;
         $display("FAIL frame_end: state %0d valid %b fcnt %0d want state %0d valid 0 fcnt 1",
                  dbg_state, out_valid, frame_count, ST_LISTEN);
      end
      n_cmp++;
      if ({start_cnt - s0, read_cnt - r0, beat_cnt - b0} !== {32'd1, 32'd8, 32'd8}) begin
         n_err++;
         $display("FAIL frame_counts: starts %0d reads %0d beats %0d want 1 8 8",
                  start_cnt - s0, read_cnt - r0, beat_cnt - b0);
      end
   endtask

   task automatic test_partial_full();
      int s0, bad;
      do_reset();
      enable = 1'b1;
      buf_full = 2'b01;
      s0 = start_cnt;
      bad = 0;
      repeat (50) begin
         tick();
         if (dbg_state !== ST_LISTEN || buf_write_en !== 2'b11) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL partial_hold: %0d bad cycles want 0", bad);
      end
      n_cmp++;
      if (start_cnt - s0 !== 0) begin
         n_err++;
         $display("FAIL partial_no_start: %0d starts want 0", start_cnt - s0);
      end
      buf_full = 2'b11;
      tick();
      buf_full = 2'b00;
      n_cmp++;
      if ({fft_start, dbg_state} !== {1'b1, ST_PREPARE}) begin
         n_err++;
         $display("FAIL full_start: start %b state %0d want 1 %0d", fft_start, dbg_state, ST_PREPARE);
      end
   endtask

   task automatic test_enable_gate();
      int s0;
      do_reset();
      enable = 1'b0;
      buf_full = 2'b11;
      s0 = start_cnt;
      repeat (10) tick();
      n_cmp++;
      if (dbg_state !== ST_LISTEN || start_cnt - s0 !== 0) begin
         n_err++;
         $display("FAIL enable_gate: state %0d starts %0d want %0d 0", dbg_state, start_cnt - s0, ST_LISTEN);
      end
      enable = 1'b1;
      tick();
      buf_full = 2'b00;
      n_cmp++;
      if (dbg_state !== ST_PREPARE) begin
         n_err++;
         $display("FAIL enable_release: state %0d want %0d", dbg_state, ST_PREPARE);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      start_frame();
      n_cmp++;
      if ({dbg_state, dbg_timer} !== {ST_WAIT, 5'd0}) begin
         n_err++;
         $display("FAIL wait_start: state %0d timer %0d want %0d 0", dbg_state, dbg_timer, ST_WAIT);
      end
      repeat (TIMEOUT_CYC - 1) tick();
      n_cmp++;
      if ({dbg_state, dbg_timer, timeout_err} !== {ST_WAIT, 5'd15, 1'b0}) begin
         n_err++;
         $display("FAIL wait_last: state %0d timer %0d err %b want %0d 15 0", dbg_state, dbg_timer, timeout_err, ST_WAIT);
      end
      tick();
      n_cmp++;
      if ({dbg_state, timeout_err} !== {ST_LISTEN, 1'b1}) begin
         n_err++;
         $display("FAIL timeout_expire: state %0d err %b want %0d 1", dbg_state, timeout_err, ST_LISTEN);
      end
      repeat (5) tick();
      n_cmp++;
      if (timeout_err !== 1'b1) begin
         n_err++;
         $display("FAIL timeout_sticky: err %b want 1", timeout_err);
      end
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      n_cmp++;
      if (timeout_err !== 1'b0) begin
         n_err++;
         $display("FAIL err_clear: err %b want 0", timeout_err);
      end
      // Clear held across the expiry cycle: the set must win.
      start_frame();
      repeat (TIMEOUT_CYC - 1) tick();
      err_clear = 1'b1;
      tick();
      n_cmp++;
      if ({dbg_state, timeout_err} !== {ST_LISTEN, 1'b1}) begin
         n_err++;
         $display("FAIL set_beats_clear: state %0d err %b want %0d 1", dbg_state, timeout_err, ST_LISTEN);
      end
      tick();
      err_clear = 1'b0;
      n_cmp++;
      if (timeout_err !== 1'b0) begin
         n_err++;
         $display("FAIL clear_after_set: err %b want 0", timeout_err);
      end
      // Done arriving on the expiry cycle goes to DRAIN with no error.
      start_frame();
      repeat (TIMEOUT_CYC - 1) tick();
      fft_done = 1'b1;
      tick();
      fft_done = 1'b0;
      n_cmp++;
      if ({dbg_state, out_valid, out_index, timeout_err} !== {ST_DRAIN, 1'b1, 3'd0, 1'b0}) begin
         n_err++;
         $display("FAIL done_at_expiry: state %0d valid %b idx %0d err %b want %0d 1 0 0",
                  dbg_state, out_valid, out_index, timeout_err, ST_DRAIN);
      end
      out_ready = 1'b1;
      repeat (FRAME_LEN) tick();
      out_ready = 1'b0;
      n_cmp++;
      if ({dbg_state, timeout_err, frame_count} !== {ST_LISTEN, 1'b0, 2'd1}) begin
         n_err++;
         $display("FAIL done_at_expiry_end: state %0d err %b fcnt %0d want %0d 0 1",
                  dbg_state, timeout_err, frame_count, ST_LISTEN);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] pat;
      int exp_idx, k, b0;
      do_reset();
      start_frame();
      fft_done = 1'b1;
      tick();
      fft_done = 1'b0;
      pat = 4'b1001;
      exp_idx = 0;
      k = 0;
      b0 = beat_cnt;
      while (exp_idx < FRAME_LEN && k < 100) begin
         n_cmp++;
         if ({dbg_state, out_valid, out_index} !== {ST_DRAIN, 1'b1, 3'(exp_idx)}) begin
            n_err++;
            $display("FAIL bp_cycle%0d: state %0d valid %b idx %0d want %0d 1 %0d",
                     k, dbg_state, out_valid, out_index, ST_DRAIN, exp_idx);
         end
         out_ready = pat[k % 4];
         tick();
         if (out_ready) exp_idx++;
         k++;
      end
      out_ready = 1'b0;
      n_cmp++;
      if ({32'(k), 32'(beat_cnt - b0)} !== {32'd16, 32'd8}) begin
         n_err++;
         $display("FAIL bp_length: cycles %0d beats %0d want 16 8", k, beat_cnt - b0);
      end
      n_cmp++;
      if ({dbg_state, frame_count} !== {ST_LISTEN, 2'd1}) begin
         n_err++;
         $display("FAIL bp_end: state %0d fcnt %0d want %0d 1", dbg_state, frame_count, ST_LISTEN);
      end
   endtask

   task automatic test_frame_count();
      logic [1:0] exp_fc [5];
      exp_fc = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();
      for (int f = 0; f < 5; f++) begin
         start_frame();
         fft_done = 1'b1;
         tick();
         fft_done = 1'b0;
         out_ready = 1'b1;
         repeat (FRAME_LEN) tick();
         out_ready = 1'b0;
         n_cmp++;
         if ({dbg_state, frame_count} !== {ST_LISTEN, exp_fc[f]}) begin
            n_err++;
            $display("FAIL fcnt_frame%0d: state %0d fcnt %0d want %0d %0d",
                     f, dbg_state, frame_count, ST_LISTEN, exp_fc[f]);
         end
      end
   endtask

   task automatic test_reset_mid_load();
      do_reset();
      enable = 1'b1;
      buf_full = 2'b11;
      tick();
      buf_full = 2'b00;
      repeat (6) tick();
      n_cmp++;
      if ({dbg_state, buf_read, rd_index} !== {ST_LOAD, 1'b1, 3'd5}) begin
         n_err++;
         $display("FAIL mid_load_pre: state %0d read %b idx %0d want %0d 1 5", dbg_state, buf_read, rd_index, ST_LOAD);
      end
      reset = 1'b1;
      tick();
      n_cmp++;
      if ({dbg_state, rd_index, fft_reset, buf_read, busy} !== {ST_RST, 3'd0, 1'b1, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL mid_load_reset: state %0d idx %0d fft_reset %b read %b busy %b want %0d 0 1 0 0",
                  dbg_state, rd_index, fft_reset, buf_read, busy, ST_RST);
      end
      reset = 1'b0;
      tick();
      n_cmp++;
      if (dbg_state !== ST_LISTEN) begin
         n_err++;
         $display("FAIL mid_load_release: state %0d want %0d", dbg_state, ST_LISTEN);
      end
   endtask

   // Test sequence and final report.
   initial begin
      test_reset();
      test_frame();
      test_partial_full();
      test_enable_gate();
      test_timeout();
      test_backpressure();
      test_frame_count();
      test_reset_mid_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Parametrised frame sequencer for the audio FFT path. It gates writes into NUM_CH sample buffers and waits until every buffer is full. It then streams one frame of FRAME_LEN samples into the FFT core, waits for the transform with a bounded timeout, and drains FRAME_LEN output bins to the peak/spectrum stage under valid/ready backpressure. It sits between the ADC sample buffers and the FFT core / peak detector.

## Interface
Parameters:
- N_LOG2, 9, frame length FRAME_LEN = 2**N_LOG2 (≥ 2)
- NUM_CH, 2, number of sample buffers (even/odd = 2)
- TIMEOUT_CYC, 4096, max cycles in WAIT before abort (≥ 1)
- FCNT_W, 16, frame counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  permits leaving LISTEN
- buf_full  in  NUM_CH  per-buffer full flags
- fft_done  in  1  FFT result ready (level or pulse)
- out_ready  in  1  downstream accepts current bin
- err_clear  in  1  clears timeout_err
- buf_write_en  out  NUM_CH  per-buffer write enable
- buf_read  out  1  read strobe to buffers
- rd_index  out  N_LOG2  sample index being loaded
- fft_reset  out  1  hold FFT core in reset
- fft_start  out  1  one-cycle start pulse
- peak_reset  out  1  clear peak detector
- out_valid  out  1  bin valid at out_index
- out_index  out  N_LOG2  bin index being drained
- frame_count  out  FCNT_W  completed frames, wraps
- timeout_err  out  1  sticky timeout flag
- busy  out  1  state ∉ {RST, LISTEN}

## Operation
States: RST, LISTEN, PREPARE, LOAD, WAIT, DRAIN.
- RST: buf_write_en=0, fft_reset=1. Next state is LISTEN when reset=0.
- LISTEN: buf_write_en=all 1, fft_reset=1, peak_reset=1. Next state is PREPARE when enable and &buf_full. A partial set of full flags holds the block in LISTEN.
- PREPARE (1 cycle): fft_start=1, buf_write_en=0. Clears rd_index. Next state is LOAD.
- LOAD: buf_read=1, buf_write_en=0. rd_index increments every cycle starting from 0. When rd_index==FRAME_LEN-1, the next state is WAIT. Exactly FRAME_LEN read cycles.
- WAIT: buf_write_en=0. A timer counts from 0.
  - fft_done → DRAIN, with out_index=0.
  - Otherwise, when timer==TIMEOUT_CYC-1 → LISTEN, and timeout_err is set.
  - fft_done in the same cycle as expiry: fft_done wins.
- DRAIN: out_valid=1, buf_write_en=0. out_index increments only on out_valid&&out_ready. When the beat at index FRAME_LEN-1 is accepted, the next state is LISTEN and frame_count increments (mod 2**FCNT_W).
- All outputs not listed for a state are 0.
- timeout_err is sticky. It is cleared by err_clear or reset. If set and clear occur in the same cycle, set wins.
- Counters are N_LOG2 bits and wrap naturally; there is no extra terminal-count bit. The WAIT timer is $clog2(TIMEOUT_CYC+1) bits.

## Timing
- Reset (any state, mid-frame included) → RST on the next edge.
- Reset values: state=RST, rd_index=0, out_index=0, frame_count=0, timeout_err=0, timer=0. Outputs in RST: fft_reset=1, all others 0.
- Reset released at edge k → LISTEN at k+1.
- All buffers full at edge t (in LISTEN, enabled) → fft_start high in cycle t+1 → buf_read high for cycles t+2 … t+1+FRAME_LEN → WAIT from t+2+FRAME_LEN.
- fft_done sampled in WAIT → out_valid high on the next cycle.
- With out_ready held high, DRAIN lasts FRAME_LEN cycles. Each cycle with out_ready=0 extends DRAIN by one cycle, and out_index holds.
- Outputs are Moore (decoded from registered state/counters). No input→output combinational path.

## Structure
- Package fft_seq_pkg holds:
  - the state enum typedef (logic [2:0])
  - the default N_LOG2/NUM_CH constants, shared with the buffer and FFT wrappers
- One sub-module is natural: seq_counter (enable/clear up-counter with terminal-count flag). It is instantiated for rd_index, out_index and the WAIT timer.

## Test plan
- Reset mid-LOAD (rd_index=100) → next cycle state RST, rd_index=0, fft_reset=1, buf_read=0; LISTEN one cycle after release.
- N_LOG2=3, NUM_CH=2, both full, fft_done 5 cycles later, out_ready=1 → exactly 1 fft_start pulse, 8 buf_read cycles with rd_index 0..7, 8 out_valid beats with out_index 0..7, frame_count=1.
- buf_full=2'b01 held 50 cycles → stays in LISTEN with buf_write_en=2'b11 and no fft_start; set 2'b11 → fft_start follows one cycle later.
- TIMEOUT_CYC=16, no fft_done → after 16 WAIT cycles returns to LISTEN, timeout_err=1 and stays set; err_clear pulse → 0; fft_done on the expiry cycle → DRAIN, timeout_err stays 0.
- DRAIN with out_ready toggling 1,0,0,1… → out_index advances only on ready cycles; total beats FRAME_LEN, no index skipped or repeated.
- FCNT_W=2, 5 frames → frame_count sequence 1,2,3,0,1; enable=0 in LISTEN with all full → no PREPARE.
